// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with single-entry valid/ready holding register,
//            framing-error and overrun pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk_in,
  input  logic       sys_rstn,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] HALF_LOAD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic        sync1;
  logic        rxs;
  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [2:0]  bidx;
  logic [2:0]  bidx_nxt;
  logic [7:0]  shreg;
  logic [7:0]  shreg_nxt;
  logic        deliver;
  logic        deliver_nxt;
  logic        ferr_nxt;
  logic        tick;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      rxs   <= sync1;
    end
  end

  assign tick = (state != S_IDLE) && (cnt == 16'd0);

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      bidx      <= 3'd0;
      shreg     <= 8'd0;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bidx      <= bidx_nxt;
      shreg     <= shreg_nxt;
      deliver   <= deliver_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt != 16'd0) ? cnt - 16'd1 : cnt;
    bidx_nxt    = bidx;
    shreg_nxt   = shreg;
    deliver_nxt = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          cnt_nxt   = HALF_LOAD;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxs) begin
            cnt_nxt   = FULL_LOAD;
            bidx_nxt  = 3'd0;
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_nxt = {rxs, shreg[7:1]};
          cnt_nxt   = FULL_LOAD;
          if (bidx == 3'd7) begin
            state_nxt = S_STOP;
          end else begin
            bidx_nxt = bidx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rxs) begin
            deliver_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Stay here while the line is held low so a break yields one error.
        if (rxs) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Holding register: a delivery wins over a same-cycle handshake.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (BAUD_DIV = 16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int BAUD_DIV = 16;

  logic       clk_in;
  logic       sys_rstn;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks;
  int errors;
  int ferr_cnt;
  int ovr_cnt;
  int rise_j;
  int ovr_j;
  int ferr_j;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk_in   (clk_in),
    .sys_rstn (sys_rstn),
    .uart_rxd (uart_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse counters and mutual-exclusion watch, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) check("err_ovr_exclusive", 32'd1, 32'd0);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      uart_rxd = 1'b1;
    end
  endtask

  // Drives one 8N1 frame from a negedge. Within the stop bit, index j marks the
  // negedge preceding frame edge 145+j, so state after the delivery edge shows at j=12.
  task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic ready_pulse);
    logic val;
    logic prev_v;
    rise_j = -1;
    ovr_j  = -1;
    ferr_j = -1;
    prev_v = rx_valid;
    for (int b = 0; b < 10; b++) begin
      if (b == 0) val = 1'b0;
      else if (b == 9) val = stop_val;
      else val = d[b-1];
      for (int j = 0; j < BAUD_DIV; j++) begin
        @(negedge clk_in);
        if (b == 9) begin
          if (rx_valid && !prev_v && rise_j < 0) rise_j = j;
          if (overrun) ovr_j = j;
          if (frame_err) ferr_j = j;
          prev_v   = rx_valid;
          rx_ready = ready_pulse && (j == 11);
        end
        uart_rxd = val;
      end
    end
  endtask

  task automatic drain(input logic [7:0] exp_data);
    @(negedge clk_in);
    rx_ready = 1'b1;
    @(negedge clk_in);
    rx_ready = 1'b0;
    check("drain_valid", {31'd0, rx_valid}, 32'd0);
    check("drain_data", {24'd0, rx_data}, {24'd0, exp_data});
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ferr_cnt = 0;
    ovr_cnt  = 0;
    uart_rxd = 1'b1;
    rx_ready = 1'b0;
    sys_rstn = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    sys_rstn = 1'b1;
    idle(5);

    // Frame 0x55, consumer not ready.
    send_frame(8'h55, 1'b1, 1'b0);
    check("f55_rise", rise_j, 32'd12);
    check("f55_data", {24'd0, rx_data}, 32'h55);
    check("f55_ferr", ferr_cnt, 32'd0);
    check("f55_ovr", ovr_cnt, 32'd0);
    idle(10);
    check("f55_hold", {31'd0, rx_valid}, 32'd1);
    drain(8'h55);

    // Short low glitch is rejected at the start-bit sample.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      uart_rxd = 1'b0;
    end
    idle(20);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_ferr", ferr_cnt, 32'd0);
    send_frame(8'hA3, 1'b1, 1'b0);
    check("fa3_rise", rise_j, 32'd12);
    check("fa3_data", {24'd0, rx_data}, 32'hA3);
    drain(8'hA3);

    // Framing error followed by a held-low line.
    send_frame(8'h3C, 1'b0, 1'b0);
    check("f3c_ferr_time", ferr_j, 32'd11);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      uart_rxd = 1'b0;
    end
    check("break_ferr_cnt", ferr_cnt, 32'd1);
    check("break_valid", {31'd0, rx_valid}, 32'd0);
    check("break_busy", {31'd0, busy}, 32'd1);
    idle(20);
    check("break_exit", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    check("f81_data", {24'd0, rx_data}, 32'h81);
    check("f81_ferr_cnt", ferr_cnt, 32'd1);
    drain(8'h81);

    // Back-to-back frames with consumer stalled: second byte overruns.
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    check("ovr_time", ovr_j, 32'd12);
    check("ovr_cnt", ovr_cnt, 32'd1);
    check("ovr_data", {24'd0, rx_data}, 32'h12);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    drain(8'h12);

    // Handshake coincides with the second delivery: no overrun.
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1);
    check("hs_ovr_cnt", ovr_cnt, 32'd1);
    check("hs_ovr_time", ovr_j, 32'hFFFF_FFFF);
    check("hs_valid", {31'd0, rx_valid}, 32'd1);
    check("hs_data", {24'd0, rx_data}, 32'h34);

    // Reset during data bit 4 of 0xFF, holding register still full.
    for (int i = 0; i < BAUD_DIV; i++) begin
      @(negedge clk_in);
      uart_rxd = 1'b0;
    end
    for (int i = 0; i < 4 * BAUD_DIV + BAUD_DIV / 2; i++) begin
      @(negedge clk_in);
      uart_rxd = 1'b1;
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    sys_rstn = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_data", {24'd0, rx_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_flags", {30'd0, frame_err, overrun}, 32'd0);
    idle(4);
    sys_rstn = 1'b1;
    idle(200);
    check("post_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("post_rst_ferr", ferr_cnt, 32'd1);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("f5a_rise", rise_j, 32'd12);
    check("f5a_data", {24'd0, rx_data}, 32'h5A);
    drain(8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
